debounce_pulse_gen: RTL and testbench
=====================================

// Module: debounce_pulse_gen
// PURPOSE
//  Conditions a raw asynchronous input (push-button or switch) into a clean,
//  single-cycle pulse per debounced rising edge. Sits directly upstream of the
//  Moore sequence FSM and drives its `in` port, so that FSM advances exactly one
//  state per physical press. Also reports the debounced level and a count of
//  rejected glitches for bring-up.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable samples needed to accept an edge (>=2)
//  CNT_W            3  width of debounce counter; 2**CNT_W must be >= DEBOUNCE_CYCLES
//  GLITCH_W         8  width of glitch counter
// PORTS
//  clk          in   1         clock, all logic on posedge
//  rst          in   1         reset, synchronous, active-low
//  raw_in       in   1         asynchronous raw input
//  enable       in   1         1 = pulse_out permitted; 0 = pulses suppressed
//  pulse_out    out  1         one-cycle high per accepted rising edge (to FSM `in`)
//  level_out    out  1         debounced level
//  glitch_cnt   out  GLITCH_W  saturating count of aborted edge qualifications
// BEHAVIOUR
//  Reset (rst==0 at posedge): sync_q1=sync_q2=0, state=IDLE_LOW, cnt=0,
//   pulse_out=0, level_out=0, glitch_cnt=0. Reset overrides all other activity,
//   including a qualification in progress.
//  Synchronizer: two flops, raw_in -> sync_q1 -> sync_q2. FSM samples sync_q2 only.
//  States (2-bit): IDLE_LOW=0, RISE_WAIT=1, IDLE_HIGH=2, FALL_WAIT=3.
//   IDLE_LOW : sync_q2=1 -> RISE_WAIT, cnt=1; else stay, cnt=0.
//   RISE_WAIT: sync_q2=0 -> IDLE_LOW, cnt=0, glitch_cnt+1.
//              sync_q2=1 & cnt==DEBOUNCE_CYCLES-1 -> IDLE_HIGH, cnt=0,
//              level_out=1, pulse_out=enable.
//              sync_q2=1 otherwise -> stay, cnt+1.
//   IDLE_HIGH: sync_q2=0 -> FALL_WAIT, cnt=1; else stay.
//   FALL_WAIT: sync_q2=1 -> IDLE_HIGH, cnt=0, glitch_cnt+1.
//              sync_q2=0 & cnt==DEBOUNCE_CYCLES-1 -> IDLE_LOW, cnt=0, level_out=0.
//              sync_q2=0 otherwise -> stay, cnt+1.
//  pulse_out is registered; high for exactly one cycle, then 0 on the next edge
//   regardless of inputs. No pulse on falling edges.
//  Latency: raw_in rising and held from before edge 0 -> pulse_out/level_out
//   high after edge DEBOUNCE_CYCLES+1 (2 sync + DEBOUNCE_CYCLES samples).
//   Falling: level_out low after the same number of edges.
//  enable affects only pulse_out; state/level/glitch tracking continue. enable
//   is sampled on the accepting edge only; an edge accepted with enable=0 is lost.
//  glitch_cnt saturates at all-ones; no wrap.
//  Default state encoding -> IDLE_LOW, cnt=0 (recovery).
//  Post-reset with raw_in already high: treated as a new rising edge; one pulse
//   after DEBOUNCE_CYCLES+2 edges from reset release.
// TESTING
//  1 rst=0 2 cycles, raw_in=1 -> all outputs 0 during reset; glitch_cnt=0.
//  2 raw_in 0->1 held 10 cycles, enable=1, DEBOUNCE_CYCLES=4 -> pulse_out high
//    exactly one cycle after 5th edge; level_out=1 from then on.
//  3 raw_in high 2 cycles then low -> no pulse, level_out=0, glitch_cnt=1;
//    repeat 300 times -> glitch_cnt saturates at 255.
//  4 accepted high, raw_in low 4 cycles then high -> level_out=0, then a second
//    pulse; low glitch of 1 cycle while high -> no pulse, glitch_cnt+1.
//  5 enable=0 during accepted rise -> level_out=1, pulse_out stays 0.
//  6 rst=0 asserted while in RISE_WAIT (cnt=2) -> state IDLE_LOW, cnt=0, no pulse;
//    raw_in held high after release -> one pulse 6 edges later; chain to
//    sequence FSM: 4 presses -> FSM out=1.

Source files
------------

// File: rtl/debounce_pulse_gen.sv
// Debounces a raw asynchronous input and emits one clock pulse per accepted rising edge.
// Also reports the debounced level and a saturating count of aborted qualifications.
//
//  state     | meaning
//  IDLE_LOW  | debounced level low, waiting for a high sample
//  RISE_WAIT | counting consecutive high samples toward acceptance
//  IDLE_HIGH | debounced level high, waiting for a low sample
//  FALL_WAIT | counting consecutive low samples toward acceptance
module debounce_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                raw_in,
    input  logic                enable,
    output logic                pulse_out,
    output logic                level_out,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        RISE_WAIT = 2'd1,
        IDLE_HIGH = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync_q1;
    logic             sync_q2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            state      <= IDLE_LOW;
            cnt        <= '0;
            pulse_out  <= 1'b0;
            level_out  <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            sync_q1   <= raw_in;
            sync_q2   <= sync_q1;
            // Pulse is only ever raised on the accepting edge below.
            pulse_out <= 1'b0;
            case (state)
                IDLE_LOW: begin
                    if (sync_q2) begin
                        state <= RISE_WAIT;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                RISE_WAIT: begin
                    if (!sync_q2) begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                        if (glitch_cnt != GLITCH_MAX)
                            glitch_cnt <= glitch_cnt + 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE_HIGH;
                        cnt       <= '0;
                        level_out <= 1'b1;
                        pulse_out <= enable;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_q2) begin
                        state <= FALL_WAIT;
                        cnt   <= CNT_W'(1);
                    end
                end
                FALL_WAIT: begin
                    if (sync_q2) begin
                        state <= IDLE_HIGH;
                        cnt   <= '0;
                        if (glitch_cnt != GLITCH_MAX)
                            glitch_cnt <= glitch_cnt + 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE_LOW;
                        cnt       <= '0;
                        level_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LOW;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Scoreboard bench for debounce_pulse_gen: a run-length reference model pushes
// the expected outputs per edge, which are popped and compared after the edge.
module tb_debounce_pulse_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_in;
    logic       enable;
    logic       pulse_out;
    logic       level_out;
    logic [7:0] glitch_cnt;

    debounce_pulse_gen #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .GLITCH_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .enable     (enable),
        .pulse_out  (pulse_out),
        .level_out  (level_out),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pulse;
        logic       level;
        logic [7:0] glitch;
    } exp_t;

    exp_t exp_q[$];

    int checks      = 0;
    int failures    = 0;
    int cyc         = 0;
    int pulse_total = 0;
    int last_pulse  = -1;

    // reference model: 2-flop delay plus a run length of samples that disagree with the level
    logic m_q1 = 1'b0, m_q2 = 1'b0, m_lvl = 1'b0, m_pulse = 1'b0;
    int   m_run = 0, m_glitch = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic rb);
        exp_t x;
        logic s;
        raw_in = r;
        enable = e;
        rst    = rb;
        if (!rb) begin
            m_q1 = 0; m_q2 = 0; m_lvl = 0; m_run = 0; m_glitch = 0; m_pulse = 0;
        end else begin
            s       = m_q2;
            m_q2    = m_q1;
            m_q1    = r;
            m_pulse = 1'b0;
            if (s != m_lvl) begin
                m_run++;
                if (m_run == 4) begin
                    m_lvl   = s;
                    m_pulse = s & e;
                    m_run   = 0;
                end
            end else begin
                if (m_run > 0 && m_glitch < 255) m_glitch++;
                m_run = 0;
            end
        end
        exp_q.push_back('{pulse: m_pulse, level: m_lvl, glitch: 8'(m_glitch)});
        @(posedge clk);
        #1;
        cyc++;
        x = exp_q.pop_front();
        check("pulse_out", 32'(pulse_out), 32'(x.pulse));
        check("level_out", 32'(level_out), 32'(x.level));
        check("glitch_cnt", 32'(glitch_cnt), 32'(x.glitch));
        if (pulse_out === 1'b1) begin
            pulse_total++;
            last_pulse = cyc;
        end
    endtask

    task automatic run(input logic r, input logic e, input int n);
        for (int i = 0; i < n; i++) step(r, e, 1'b1);
    endtask

    int rel, p0;

    initial begin
        raw_in = 1'b0;
        enable = 1'b1;
        rst    = 1'b0;

        // reset held with raw high, then release with raw still high
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("rst_pulse", 32'(pulse_out), 0);
        check("rst_level", 32'(level_out), 0);
        check("rst_glitch", 32'(glitch_cnt), 0);
        rel = cyc; p0 = pulse_total;
        run(1'b1, 1'b1, 10);
        check("post_rst_pulses", 32'(pulse_total - p0), 1);
        check("post_rst_latency", 32'(last_pulse - rel), 6);

        // clean rise after a settled low
        run(1'b0, 1'b1, 10);
        check("fall_level", 32'(level_out), 0);
        rel = cyc; p0 = pulse_total;
        run(1'b1, 1'b1, 10);
        check("rise_pulses", 32'(pulse_total - p0), 1);
        check("rise_latency", 32'(last_pulse - rel), 6);
        check("rise_level", 32'(level_out), 1);

        // low for exactly 4 cycles then high: fall accepted, then a second pulse
        p0 = pulse_total;
        run(1'b0, 1'b1, 4);
        run(1'b1, 1'b1, 3);
        check("short_fall_level", 32'(level_out), 0);
        run(1'b1, 1'b1, 7);
        check("second_pulse", 32'(pulse_total - p0), 1);

        // one-cycle low glitch while high
        p0 = pulse_total;
        run(1'b0, 1'b1, 1);
        run(1'b1, 1'b1, 8);
        check("low_glitch_pulses", 32'(pulse_total - p0), 0);
        check("low_glitch_cnt", 32'(glitch_cnt), 1);
        check("low_glitch_level", 32'(level_out), 1);

        // short high glitches from low, until saturation
        run(1'b0, 1'b1, 10);
        p0 = pulse_total;
        run(1'b1, 1'b1, 2);
        run(1'b0, 1'b1, 4);
        check("high_glitch_cnt", 32'(glitch_cnt), 2);
        check("high_glitch_level", 32'(level_out), 0);
        for (int i = 0; i < 300; i++) begin
            run(1'b1, 1'b1, 2);
            run(1'b0, 1'b1, 4);
        end
        check("glitch_saturate", 32'(glitch_cnt), 255);
        check("glitch_no_pulse", 32'(pulse_total - p0), 0);

        // rise accepted with enable low: level follows, pulse lost
        p0 = pulse_total;
        run(1'b1, 1'b0, 10);
        check("en0_level", 32'(level_out), 1);
        check("en0_pulses", 32'(pulse_total - p0), 0);
        run(1'b0, 1'b1, 10);

        // reset in the middle of a rise qualification
        p0 = pulse_total;
        run(1'b1, 1'b1, 4);
        step(1'b1, 1'b1, 1'b0);
        check("mid_rst_pulses", 32'(pulse_total - p0), 0);
        check("mid_rst_glitch", 32'(glitch_cnt), 0);
        rel = cyc;
        run(1'b1, 1'b1, 10);
        check("mid_rst_after", 32'(pulse_total - p0), 1);
        check("mid_rst_latency", 32'(last_pulse - rel), 6);
        run(1'b0, 1'b1, 10);

        // four clean presses: downstream sequence FSM sees exactly four pulses
        p0 = pulse_total;
        for (int i = 0; i < 4; i++) begin
            run(1'b1, 1'b1, 8);
            run(1'b0, 1'b1, 8);
        end
        check("presses_to_fsm", 32'(pulse_total - p0), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
